// File: rtl/move_queue.sv
// move_queue: circular FIFO of 2-bit move-direction codes.
//
// Each cycle at most one of the four move-event pulses is accepted. The
// priority is in1 > in2 > in3 > in4. The accepted event is stored as its
// direction code (in1=00, in2=01, in3=10, in4=11). Any other events that
// arrive in the same cycle are dropped.
//
// Handshake: valid/ready. The head entry transfers on any rising edge where
// valid=1 and ready=1. While valid=1 and ready=0, dir holds its value.
// ready has no effect while valid=0.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in1..in4   move-event pulses; a level held high counts once per cycle
//   ready      consumer takes the head entry
//   valid      queue holds at least one entry
//   dir        direction code of the head entry (2'b00 while empty)
//   count      number of occupied entries, 0..DEPTH
//   full       count == DEPTH
//   overflow   registered one-cycle pulse: an event was discarded
module move_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in1,
  input  logic                     in2,
  input  logic                     in3,
  input  logic                     in4,
  input  logic                     ready,
  output logic                     valid,
  output logic [1:0]               dir,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf_q;

  logic          any_ev;
  logic          multi_ev;
  logic [1:0]    code;
  logic          is_full;
  logic          push;
  logic          pop;
  logic          drop;

  // Select one event by priority and detect whether others were lost.
  always_comb begin
    code     = 2'b11;
    any_ev   = in1 | in2 | in3 | in4;
    multi_ev = (in1 & (in2 | in3 | in4)) | (in2 & (in3 | in4)) | (in3 & in4);
    if (in1)      code = 2'b00;
    else if (in2) code = 2'b01;
    else if (in3) code = 2'b10;
  end

  assign is_full = (cnt == CW'(DEPTH));
  assign pop     = valid & ready;
  // When the queue is full, a pop in the same cycle frees a slot for the push.
  assign push    = any_ev & (~is_full | pop);
  assign drop    = any_ev & is_full & ~pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      // The pointers are AW bits wide and DEPTH is a power of two,
      // so they wrap modulo DEPTH without extra logic.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      ovf_q <= drop | multi_ev;
    end
  end

  // Entry storage is not reset. An empty queue masks dir, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr] <= code;
  end

  assign valid    = (cnt != '0);
  assign full     = is_full;
  assign count    = cnt;
  assign overflow = ovf_q;
  assign dir      = valid ? mem[rd_ptr] : 2'b00;

endmodule

// File: tb/tb_move_queue.sv
module tb_move_queue;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in1 = 1'b0, in2 = 1'b0, in3 = 1'b0, in4 = 1'b0;
  logic       ready = 1'b0;
  logic       valid;
  logic [1:0] dir;
  logic [2:0] count;
  logic       full;
  logic       overflow;

  always #5 clk = ~clk;

  move_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4),
    .ready(ready),
    .valid(valid), .dir(dir), .count(count), .full(full), .overflow(overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] exp_q[$];   // queue contents as seen by the consumer
  bit         m_ov;       // expected overflow after the edge

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // The model works one cycle at a time. It pops the head if ready is
  // high and the queue is non-empty, then appends the highest-priority
  // event if there is room. An event is discarded if it finds no room,
  // or if two or more events arrive in the same cycle.
  task automatic model_step(input logic r, input logic [3:0] ins, input logic rdy);
    int   n;
    bit   do_pop, accept;
    logic [1:0] c;
    n = $countones(ins);
    c = 2'b00;
    for (int i = 3; i >= 0; i--) if (ins[i]) c = 2'(i);
    if (r) begin
      exp_q.delete();
      m_ov = 1'b0;
    end else begin
      do_pop = (exp_q.size() > 0) && rdy;
      accept = (n > 0) && ((exp_q.size() < DEPTH) || do_pop);
      m_ov   = ((n > 0) && !accept) || (n > 1);
      if (do_pop) void'(exp_q.pop_front());
      if (accept) exp_q.push_back(c);
    end
  endtask

  // ---------------- driver ----------------
  // ins bit0=in1 .. bit3=in4. Inputs are driven at the negedge and the
  // outputs are sampled 1 time unit after the following posedge.
  task automatic apply(input logic r, input logic [3:0] ins, input logic rdy);
    @(negedge clk);
    reset = r;
    {in4, in3, in2, in1} = ins;
    ready = rdy;
    model_step(r, ins, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"},    int'(valid),    int'(exp_q.size() != 0));
    check({tag, ".count"},    int'(count),    exp_q.size());
    check({tag, ".full"},     int'(full),     int'(exp_q.size() == DEPTH));
    check({tag, ".overflow"}, int'(overflow), int'(m_ov));
    if (exp_q.size() != 0) check({tag, ".dir"}, int'(dir), int'(exp_q[0]));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       r;
    logic [3:0] ins;
    logic       rdy;
    logic       ev;
    logic       chk_dir;
    logic [1:0] ed;
    int         ec;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic [3:0] ins, input logic rdy,
                     input logic ev, input logic chk_dir, input logic [1:0] ed,
                     input int ec, input logic ef, input logic eo);
    vec_t v;
    v.r = r; v.ins = ins; v.rdy = rdy; v.ev = ev; v.chk_dir = chk_dir;
    v.ed = ed; v.ec = ec; v.ef = ef; v.eo = eo;
    tbl.push_back(v);
  endtask

  initial begin
    logic [3:0] ins;
    logic [1:0] code;

    //   r  ins      rdy  v  cd  dir    cnt full ovf
    row(1, 4'b0000, 0,   0, 1, 2'b00, 0,  0,   0);  // reset state
    // single event
    row(0, 4'b0100, 0,   1, 1, 2'b10, 1,  0,   0);
    row(0, 4'b0000, 1,   0, 0, 2'b00, 0,  0,   0);
    // priority: in2,in3,in4 together -> 01 kept, overflow pulse
    row(0, 4'b1110, 0,   1, 1, 2'b01, 1,  0,   1);
    row(0, 4'b0000, 0,   1, 1, 2'b01, 1,  0,   0);
    row(0, 4'b0000, 1,   0, 0, 2'b00, 0,  0,   0);
    // fill and overflow
    row(0, 4'b0001, 0,   1, 1, 2'b00, 1,  0,   0);
    row(0, 4'b0010, 0,   1, 1, 2'b00, 2,  0,   0);
    row(0, 4'b0100, 0,   1, 1, 2'b00, 3,  0,   0);
    row(0, 4'b1000, 0,   1, 1, 2'b00, 4,  1,   0);
    row(0, 4'b0001, 0,   1, 1, 2'b00, 4,  1,   1);
    row(0, 4'b0000, 0,   1, 1, 2'b00, 4,  1,   0);
    // full with simultaneous push and pop: 00 leaves, 01 enters at tail
    row(0, 4'b0010, 1,   1, 1, 2'b01, 4,  1,   0);
    row(0, 4'b0000, 1,   1, 1, 2'b10, 3,  0,   0);
    row(0, 4'b0000, 1,   1, 1, 2'b11, 2,  0,   0);
    row(0, 4'b0000, 1,   1, 1, 2'b01, 1,  0,   0);
    row(0, 4'b0000, 1,   0, 0, 2'b00, 0,  0,   0);
    // reset mid-operation; in4 pulsed during reset is lost
    row(0, 4'b0001, 0,   1, 1, 2'b00, 1,  0,   0);
    row(0, 4'b0010, 0,   1, 1, 2'b00, 2,  0,   0);
    row(0, 4'b0100, 0,   1, 1, 2'b00, 3,  0,   0);
    row(1, 4'b1000, 1,   0, 1, 2'b00, 0,  0,   0);
    row(0, 4'b1000, 0,   1, 1, 2'b11, 1,  0,   0);
    row(0, 4'b0000, 1,   0, 0, 2'b00, 0,  0,   0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].r, tbl[i].ins, tbl[i].rdy);
      check($sformatf("row%0d.valid", i),    int'(valid),    int'(tbl[i].ev));
      check($sformatf("row%0d.count", i),    int'(count),    tbl[i].ec);
      check($sformatf("row%0d.full", i),     int'(full),     int'(tbl[i].ef));
      check($sformatf("row%0d.overflow", i), int'(overflow), int'(tbl[i].eo));
      if (tbl[i].chk_dir) check($sformatf("row%0d.dir", i), int'(dir), int'(tbl[i].ed));
    end

    // ---- wrap-around: 10 push/pop pairs with random codes ----
    for (int k = 0; k < 10; k++) begin
      code = 2'($urandom_range(0, 3));
      ins  = 4'b0001 << code;
      apply(0, ins, 0);
      check("wrap.count_push", int'(count), 1);
      check("wrap.dir", int'(dir), int'(code));
      apply(0, 4'b0000, 1);
      check("wrap.count_pop", int'(count), 0);
    end

    // ---- head stability with ready low ----
    apply(0, 4'b0100, 0);
    for (int k = 0; k < 3; k++) begin
      apply(0, 4'b0000, 0);
      check("hold.dir", int'(dir), 2);
    end
    apply(1, 4'b0000, 0);
    check_model("post_reset");

    // ---- randomized run against the model ----
    for (int k = 0; k < 400; k++) begin
      logic r;
      r = ($urandom_range(0, 59) == 0);
      for (int b = 0; b < 4; b++) ins[b] = ($urandom_range(0, 2) == 0);
      apply(r, ins, 1'($urandom_range(0, 1)));
      check_model("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/move_queue.md
MOVE_QUEUE -- requirements
Module: move_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in1  input  1  one-cycle move-event pulse, direction code 2'b00.
REQ-005 in2  input  1  one-cycle move-event pulse, direction code 2'b01.
REQ-006 in3  input  1  one-cycle move-event pulse, direction code 2'b10.
REQ-007 in4  input  1  one-cycle move-event pulse, direction code 2'b11.
REQ-008 ready  input  1  the consumer SHALL assert this to take the head entry.
REQ-009 valid  output  1  asserted while the queue holds one or more entries.
REQ-010 dir  output  2  direction code of the head entry; meaningful only while valid=1.
REQ-011 count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-012 full  output  1  asserted while count==DEPTH.
REQ-013 overflow  output  1  registered one-cycle pulse reporting that an event was discarded.

Function
REQ-014 The module SHALL implement the queue as a circular buffer of DEPTH 2-bit entries, with write pointer, read pointer and occupancy counter.
REQ-015 Input selection: when any of in1..in4 is high, exactly one event SHALL be chosen per cycle, with priority in1 > in2 > in3 > in4.
REQ-016 Input selection: the remaining simultaneous events SHALL be discarded.
REQ-017 Push: a push SHALL occur when an event is chosen and either count<DEPTH or a pop occurs in the same cycle.
REQ-018 Push effect: a push SHALL write the chosen code at the write pointer and advance the pointer modulo DEPTH.
REQ-019 Pop: a pop SHALL occur when valid=1 and ready=1.
REQ-020 Pop effect: a pop SHALL advance the read pointer modulo DEPTH.
REQ-021 Pop with valid=0 SHALL have no effect.
REQ-022 Count update: count SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push and pop.
REQ-023 Count range: count SHALL never exceed DEPTH and never underflow.
REQ-024 Latency: an event pushed into an empty queue SHALL appear as valid=1 with its dir on the first clock edge after the pulse.
REQ-025 No bypass: an event SHALL never be visible in the same cycle as its input pulse.
REQ-026 Ordering: entries SHALL be delivered strictly first-in first-out.
REQ-027 Head stability: dir SHALL remain stable while valid=1 and ready=0.
REQ-028 Full with simultaneous push and pop: the push SHALL be accepted, count SHALL remain DEPTH, and overflow SHALL not assert.
REQ-029 Overflow: overflow SHALL assert for exactly one cycle, on the edge after the event, when an event is chosen, count==DEPTH and no pop occurs.
REQ-030 Overflow: overflow SHALL also assert for exactly one cycle, on the edge after the event, when two or more of in1..in4 are high in the same cycle.
REQ-031 Overflow on a discard SHALL leave count and the stored entries unchanged.
REQ-032 Pointer wrap-around SHALL be transparent: a DEPTH+1-th push after one pop SHALL be stored and delivered in order.
REQ-033 Level inputs held high SHALL be treated as one event per cycle; the module SHALL perform no edge detection of its own.
REQ-034 valid SHALL equal (count!=0) and full SHALL equal (count==DEPTH), both derived from registered state.

Reset
REQ-035 While reset=1 at a rising edge, pointers and count SHALL clear to 0, giving valid=0, full=0, count=0 and overflow=0 on the next cycle.
REQ-036 Reset SHALL take priority over simultaneous push and pop.
REQ-037 Reset mid-operation SHALL discard all queued entries; events pulsed in the reset cycle SHALL be lost.
REQ-038 dir SHALL be 2'b00 after reset; stored entry contents need not be cleared.

Verification
REQ-039 Single event: reset, then in3 pulse with ready=0 -> next cycle valid=1, dir=2'b10, count=1; ready=1 for one cycle -> valid=0, count=0.
REQ-040 Priority: in2, in3 and in4 high in the same cycle -> one entry dir=2'b01, count=1, overflow=1 for one cycle.
REQ-041 Fill and overflow: DEPTH=4, ready=0, pulses in1,in2,in3,in4,in1 -> count=4, full=1, one overflow pulse after the fifth event; pops yield 00,01,10,11.
REQ-042 Full with simultaneous push and pop: queue full, in2 pulse with ready=1 -> count stays 4, overflow=0, head advances, 01 delivered last.
REQ-043 Wrap-around: 10 alternating push/pop pairs with random codes -> output sequence equals input sequence, count never exceeds 1.
REQ-044 Reset mid-operation: count=3, assert reset for one cycle -> valid=0, count=0; a new in4 pulse -> dir=2'b11.
